uart_rx_oversampler: RTL
========================

// Module: uart_rx_oversampler
// PURPOSE
//  UART receiver front end: samples async RX pin at 16x baud, deframes 8N1 characters, emits one byte per frame.
//  Sits directly upstream of the memory-mapped peripheral's RX buffer; that buffer writes rx_data on every sysclk with rx_valid high.
//  Replaces separate baud-generator/receiver pair on the RX path with one self-timed block; TX path untouched.
// PARAMETERS
//  CLK_FREQ    100_000_000  sysclk frequency, Hz
//  BAUD        9600         line rate, bit/s
//  OVERSAMPLE  16           samples per bit; fixed, not overridden
//  DIV         CLK_FREQ/(BAUD*OVERSAMPLE)  sysclk cycles per sample tick; 651 at defaults, integer-truncated
// PORTS
//  sysclk     in   1  clock; all state on posedge sysclk
//  reset      in   1  reset, asynchronous, active-high
//  rx         in   1  serial line, idle high, asynchronous to sysclk
//  rx_data    out  8  last received byte, LSB = first data bit
//  rx_valid   out  1  one-sysclk pulse, good frame; rx_data valid in same cycle
//  frame_err  out  1  one-sysclk pulse, stop bit sampled low
//  busy       out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, sync regs=1, counters=0.
//  Input: 2-flop synchronizer on rx, both flops reset to 1; decisions use synchronized value only.
//  Tick: counter 0..DIV-1, tick pulse at DIV-1, wraps to 0. Counter forced to 0 in IDLE, so sampling phase aligns to start edge.
//  Sample index s 0..15 increments per tick inside a bit. Bit value = majority of samples s=7,8,9, decided at s=9.
//  FSM:
//   IDLE: sync rx 1->0 edge -> START, busy=1.
//   START: at s=9 majority 1 -> IDLE (glitch, no pulse); else at s=15 -> DATA, bit index=0.
//   DATA: at s=9 shift majority into shift reg MSB (LSB-first assembly); at s=15 bit index+1; after bit 7 -> STOP.
//   STOP: at s=9: majority 1 -> rx_data<=shift reg, rx_valid pulse, -> IDLE;
//         majority 0 -> frame_err pulse, rx_data unchanged, -> BREAK.
//   BREAK: wait for sync rx=1, then -> IDLE.
//  Return to IDLE at mid-stop allows back-to-back frames with up to ~3% rate mismatch.
//  rx_valid and frame_err never high in same cycle; each high exactly 1 sysclk per frame.
//  rx_data holds between frames; valid pulse fires even if byte equals previous byte.
//  Reset mid-frame: partial byte discarded, no pulse; after release a held-low line starts a new frame only after it goes high then low.
//  Latency: rx_valid at sync delay + 9.5 bit times after start edge (2 + 9*16*DIV + 10*DIV sysclk, +/-1 tick).
//  Widths: tick counter clog2(DIV) bits, s 4 bits, bit index 3 bits; no arithmetic beyond increment/compare.
// STRUCTURE
//  Package uart_pkg: state encoding IDLE/START/DATA/STOP/BREAK (3-bit), OVERSAMPLE=16, MID_LO=7, MID_HI=9, LAST_SAMPLE=15,
//   DIV computation function, shared with TX side.
//  Sub-module uart_sample_tick: DIV counter with synchronous clear input, tick output; top holds synchronizer, vote, FSM, shift reg.
//  No FIFO inside: buffering stays in the peripheral.
// TESTING
//  Clean 0x55 at 9600 baud -> one rx_valid pulse, rx_data=0x55, ~9.5 bit times after start edge; frame_err stays 0.
//  Back-to-back 0xA3,0x0F,0xFF, no idle gap, TX 2% fast -> three pulses in order, data exact.
//  3-sample-tick low glitch on idle line -> return to IDLE at s=9 of START, no pulse, busy drops.
//  0x3C with stop bit driven low -> frame_err pulse, no rx_valid, rx_data keeps previous value, busy held until rx high.
//  Single-tick noise spike inverting sample s=8 of data bit 3 -> majority vote corrects, byte unchanged.
//  reset asserted during data bit 4 -> outputs 0 same cycle, no pulse; next clean 0x81 -> rx_data=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the sample-tick divider calculation used by both RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_LO      = 7;
  localparam int MID_HI      = 9;
  localparam int LAST_SAMPLE = 15;

  // sysclk cycles per oversample tick, integer-truncated
  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on DIV-1.
// A synchronous clear holds the count at 0 so the sampling phase can be
// re-aligned to a start edge.
module uart_sample_tick #(
  parameter int DIV = 651
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // divider count, wraps after the terminal value
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear || tick)
      count <= '0;
    else
      count <= count + CW'(1);
  end

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART 8N1 receiver front end with 16x oversampling and 3-sample majority vote.
//
//   state | meaning
//   IDLE  | line idle, tick counter held at 0, waiting for synchronized 1->0 edge
//   START | checking start bit; high majority at mid-bit means glitch
//   DATA  | sampling 8 data bits LSB first
//   STOP  | sampling stop bit; high = good frame, low = framing error
//   BREAK | stop bit was low; wait for line to return high
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);

  uart_state_e state, state_nxt;

  logic       rx_meta, rx_sync, rx_prev;
  logic [1:0] sync_fill;
  logic       fall, tick, tick_clear;
  logic [3:0] s;
  logic [2:0] bit_idx;
  logic       v7, v8, vote, at_mid, at_last;
  logic [7:0] shift;
  logic       shift_en, bit_adv, bit_clr, load_data, flag_err;

  // rx_prev only reflects a genuinely sampled level once the synchronizer has
  // flushed its reset value, so a line held low through reset is not an edge
  assign fall       = rx_prev & ~rx_sync;
  assign tick_clear = (state == IDLE);
  assign at_mid     = tick & (s == 4'(MID_HI));
  assign at_last    = tick & (s == 4'(LAST_SAMPLE));
  assign vote       = (v7 & v8) | (v7 & rx_sync) | (v8 & rx_sync);
  assign busy       = (state != IDLE);

  uart_sample_tick #(.DIV(DIV)) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (tick_clear),
    .tick   (tick)
  );

  // two-flop synchronizer plus qualified previous value for edge detect
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= sync_fill[1] & rx_sync;
    end
  end

  // sample index within a bit and the two early votes
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s  <= 4'd0;
      v7 <= 1'b0;
      v8 <= 1'b0;
    end else if (tick_clear) begin
      s <= 4'd0;
    end else if (tick) begin
      s <= s + 4'd1;
      if (s == 4'(MID_LO))     v7 <= rx_sync;
      if (s == 4'(MID_LO + 1)) v8 <= rx_sync;
    end
  end

  // state register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    bit_adv   = 1'b0;
    bit_clr   = 1'b0;
    load_data = 1'b0;
    flag_err  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_nxt = START;
      end
      START: begin
        if (at_mid && vote) begin
          state_nxt = IDLE;
        end else if (at_last) begin
          state_nxt = DATA;
          bit_clr   = 1'b1;
        end
      end
      DATA: begin
        if (at_mid) shift_en = 1'b1;
        if (at_last) begin
          bit_adv = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (at_mid) begin
          if (vote) begin
            load_data = 1'b1;
            state_nxt = IDLE;
          end else begin
            flag_err  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit counter, shift register and registered output pulses
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (bit_clr)
        bit_idx <= 3'd0;
      else if (bit_adv)
        bit_idx <= bit_idx + 3'd1;
      if (shift_en)
        shift <= {vote, shift[7:1]};
      if (load_data)
        rx_data <= shift;
      rx_valid  <= load_data;
      frame_err <= flag_err;
    end
  end

endmodule
